// File: rtl/stack_mem_unit_pkg.sv
// stack_mem_unit_pkg: shared op codes, FSM encoding and sizing defaults for the memory-stage stack unit
package stack_mem_unit_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int SP_RESET_DEF = (1 << ADDR_W_DEF) - 1;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_PUSH   = 3'd3,
        OP_POP    = 3'd4,
        OP_PUSH32 = 3'd5,
        OP_POP32  = 3'd6,
        OP_RDVEC  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    function automatic logic is_two_word(input op_e op);
        return op inside {OP_PUSH32, OP_POP32, OP_RDVEC};
    endfunction

endpackage

// File: rtl/stack_mem_unit_dmem_16.sv
// dmem_16: 16-bit data memory, one synchronous write port and one combinational read port
//   clk            rising-edge clock
//   we/waddr/wdata write enable, word address, data
//   raddr/rdata    read address and combinational read data
module dmem_16 #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_mem_unit.sv
// stack_mem_unit: memory-stage data/stack unit owning the data memory and SP, with two-cycle 32-bit ops
//   clk, rst                         clock, synchronous active-low reset
//   i_valid, i_op                    request strobe and op code
//   i_addr, i_data16, i_data32       address, 16-bit store/push data, 32-bit push data
//   i_wb, i_rdst                     writeback controls carried to the result
//   o_busy                           second cycle of a 32-bit op; upstream holds
//   o_valid, o_memData, o_wb, o_rdst completion strobe, read data and carried controls
//   o_sp, o_stackErr                 stack pointer and sticky overflow/underflow flag
module stack_mem_unit
    import stack_mem_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [2:0]        i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_data16,
    input  logic [31:0]       i_data32,
    input  logic [3:0]        i_wb,
    input  logic [2:0]        i_rdst,
    output logic              o_busy,
    output logic              o_valid,
    output logic [31:0]       o_memData,
    output logic [3:0]        o_wb,
    output logic [2:0]        o_rdst,
    output logic [ADDR_W-1:0] o_sp,
    output logic              o_stackErr
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       hi_q, hi_d;
    logic [3:0]        pend_wb_q, pend_wb_d;
    logic [2:0]        pend_rdst_q, pend_rdst_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        wb_q, wb_d;
    logic [2:0]        rdst_q, rdst_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;

    logic              we;
    logic [ADDR_W-1:0] waddr, raddr;
    logic [15:0]       wdata, rdata;
    op_e               op_in;
    logic [ADDR_W-1:0] sp_p1, sp_p2, sp_m1, sp_m2;

    assign op_in = op_e'(i_op);
    assign sp_p1 = sp_q + ADDR_W'(1);
    assign sp_p2 = sp_q + ADDR_W'(2);
    assign sp_m1 = sp_q - ADDR_W'(1);
    assign sp_m2 = sp_q - ADDR_W'(2);

    dmem_16 #(.ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        pend_wb_d   = pend_wb_q;
        pend_rdst_d = pend_rdst_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        wb_d        = wb_q;
        rdst_d      = rdst_q;
        sp_d        = sp_q;
        err_d       = err_q;
        we          = 1'b0;
        waddr       = sp_q;
        wdata       = i_data16;
        raddr       = i_addr;
        if (state_q == ST_SECOND) begin
            // second word: SP is only committed here so an aborted op leaves it untouched
            state_d = ST_IDLE;
            valid_d = 1'b1;
            wb_d    = pend_wb_q;
            rdst_d  = pend_rdst_q;
            raddr   = (op_q == OP_POP32) ? sp_p2 : addr_q + ADDR_W'(1);
            if (op_q == OP_PUSH32) begin
                we    = 1'b1;
                waddr = sp_m1;
                wdata = hi_q;
                sp_d  = sp_m2;
            end else begin
                data_d = {hi_q, rdata};
            end
            if (op_q == OP_POP32) sp_d = sp_p2;
        end else if (i_valid && op_in != OP_NOP) begin
            raddr = (op_in inside {OP_POP, OP_POP32}) ? sp_p1 : i_addr;
            we    = op_in inside {OP_STORE, OP_PUSH, OP_PUSH32};
            waddr = (op_in == OP_STORE) ? i_addr : sp_q;
            wdata = (op_in == OP_PUSH32) ? i_data32[15:0] : i_data16;
            if (is_two_word(op_in)) begin
                state_d     = ST_SECOND;
                op_d        = op_in;
                addr_d      = i_addr;
                pend_wb_d   = i_wb;
                pend_rdst_d = i_rdst;
                // high word: data to push later, or first word read now
                hi_d        = (op_in == OP_PUSH32) ? i_data32[31:16] : rdata;
            end else begin
                valid_d = 1'b1;
                wb_d    = i_wb;
                rdst_d  = i_rdst;
            end
            if (op_in inside {OP_LOAD, OP_POP}) data_d = {16'b0, rdata};
            if (op_in == OP_PUSH) sp_d = sp_m1;
            if (op_in == OP_POP) sp_d = sp_p1;
            err_d = err_q
                  | (op_in == OP_PUSH   && sp_q == '0)
                  | (op_in == OP_PUSH32 && sp_q < ADDR_W'(2))
                  | (op_in == OP_POP    && sp_q == SP_RESET)
                  | (op_in == OP_POP32  && sp_q > SP_RESET - ADDR_W'(2));
        end
        // reset at this edge aborts any pending write
        we = we & rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            addr_q      <= '0;
            hi_q        <= '0;
            pend_wb_q   <= '0;
            pend_rdst_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            wb_q        <= '0;
            rdst_q      <= '0;
            sp_q        <= SP_RESET;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            pend_wb_q   <= pend_wb_d;
            pend_rdst_q <= pend_rdst_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            wb_q        <= wb_d;
            rdst_q      <= rdst_d;
            sp_q        <= sp_d;
            err_q       <= err_d;
        end
    end

    assign o_busy     = (state_q == ST_SECOND);
    assign o_valid    = valid_q;
    assign o_memData  = data_q;
    assign o_wb       = wb_q;
    assign o_rdst     = rdst_q;
    assign o_sp       = sp_q;
    assign o_stackErr = err_q;

endmodule

// File: tb/tb_stack_mem_unit.sv
// tb_stack_mem_unit: table-driven, scoreboard-checked bench for stack_mem_unit
module tb_stack_mem_unit;
    import stack_mem_unit_pkg::*;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid = 1'b0;
    logic [2:0]    i_op = 3'd0;
    logic [AW-1:0] i_addr = '0;
    logic [15:0]   i_data16 = '0;
    logic [31:0]   i_data32 = '0;
    logic [3:0]    i_wb = '0;
    logic [2:0]    i_rdst = '0;
    logic          o_busy, o_valid, o_stackErr;
    logic [31:0]   o_memData;
    logic [3:0]    o_wb;
    logic [2:0]    o_rdst;
    logic [AW-1:0] o_sp;

    always #5 clk = ~clk;

    stack_mem_unit #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_op       (i_op),
        .i_addr     (i_addr),
        .i_data16   (i_data16),
        .i_data32   (i_data32),
        .i_wb       (i_wb),
        .i_rdst     (i_rdst),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_memData  (o_memData),
        .o_wb       (o_wb),
        .o_rdst     (o_rdst),
        .o_sp       (o_sp),
        .o_stackErr (o_stackErr)
    );

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [15:0]   d16;
        logic [31:0]   d32;
        logic [3:0]    wb;
        logic [2:0]    rdst;
        bit            chk;
        logic [31:0]   exp_data;
        logic [AW-1:0] exp_sp;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  wb;
        logic [2:0]  rdst;
        bit          chk;
    } sb_t;

    int   n_run = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // scoreboard: every completion strobe must match the oldest expected result
    always @(posedge clk) begin
        sb_t e;
        #1;
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL unexpected_valid: got o_valid=1, expected no pending op");
            end else begin
                e = sb.pop_front();
                if (e.chk) check("sb_data", o_memData, e.data);
                check("sb_wb", {28'b0, o_wb}, {28'b0, e.wb});
                check("sb_rdst", {29'b0, o_rdst}, {29'b0, e.rdst});
            end
        end
    end

    // entered just after a falling edge; returns just after the falling edge following completion
    task automatic run_op(input vec_t v);
        i_valid  = 1'b1;
        i_op     = v.op;
        i_addr   = v.addr;
        i_data16 = v.d16;
        i_data32 = v.d32;
        i_wb     = v.wb;
        i_rdst   = v.rdst;
        if (v.op != OP_NOP) sb.push_back('{v.exp_data, v.wb, v.rdst, v.chk});
        @(posedge clk);
        @(negedge clk);
        if (v.op >= OP_PUSH32) begin
            check("busy_2nd", {31'b0, o_busy}, 32'd1);
            check("valid_early", {31'b0, o_valid}, 32'd0);
            // request during busy must be ignored
            i_op     = OP_STORE;
            i_addr   = '0;
            i_data16 = 16'hDEAD;
            @(posedge clk);
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_op    = OP_NOP;
        check("valid", {31'b0, o_valid}, {31'b0, v.op != OP_NOP});
        check("busy", {31'b0, o_busy}, 32'd0);
        check("sp", {21'b0, o_sp}, {21'b0, v.exp_sp});
        check("err", {31'b0, o_stackErr}, {31'b0, v.exp_err});
    endtask

    task automatic check_reset_state();
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_busy", {31'b0, o_busy}, 32'd0);
        check("rst_data", o_memData, 32'd0);
        check("rst_wb", {28'b0, o_wb}, 32'd0);
        check("rst_rdst", {29'b0, o_rdst}, 32'd0);
        check("rst_sp", {21'b0, o_sp}, 32'd2047);
        check("rst_err", {31'b0, o_stackErr}, 32'd0);
    endtask

    initial begin
        //              op         addr   d16       d32           wb     rdst  chk  exp_data        sp     err
        tbl.push_back('{OP_STORE,  11'd5,    16'hBEEF, 32'h0,        4'h1, 3'd1, 0, 32'h0,         11'd2047, 1'b0});
        tbl.push_back('{OP_LOAD,   11'd5,    16'h0,    32'h0,        4'h2, 3'd2, 1, 32'h0000BEEF,  11'd2047, 1'b0});
        tbl.push_back('{OP_PUSH,   11'd0,    16'h1234, 32'h0,        4'h3, 3'd3, 0, 32'h0,         11'd2046, 1'b0});
        tbl.push_back('{OP_POP,    11'd0,    16'h0,    32'h0,        4'hA, 3'd5, 1, 32'h00001234,  11'd2047, 1'b0});
        tbl.push_back('{OP_NOP,    11'd0,    16'h0,    32'h0,        4'h0, 3'd0, 0, 32'h0,         11'd2047, 1'b0});
        tbl.push_back('{OP_PUSH32, 11'd0,    16'h0,    32'hCAFE0057, 4'h4, 3'd6, 0, 32'h0,         11'd2045, 1'b0});
        tbl.push_back('{OP_POP32,  11'd0,    16'h0,    32'h0,        4'h5, 3'd7, 1, 32'hCAFE0057,  11'd2047, 1'b0});
        tbl.push_back('{OP_STORE,  11'd0,    16'h0000, 32'h0,        4'h1, 3'd0, 0, 32'h0,         11'd2047, 1'b0});
        tbl.push_back('{OP_STORE,  11'd1,    16'h0039, 32'h0,        4'h1, 3'd0, 0, 32'h0,         11'd2047, 1'b0});
        tbl.push_back('{OP_RDVEC,  11'd0,    16'h0,    32'h0,        4'h6, 3'd2, 1, 32'h00000039,  11'd2047, 1'b0});
        tbl.push_back('{OP_LOAD,   11'd0,    16'h0,    32'h0,        4'h7, 3'd4, 1, 32'h00000000,  11'd2047, 1'b0});
        tbl.push_back('{OP_STORE,  11'd2047, 16'h7777, 32'h0,        4'h1, 3'd1, 0, 32'h0,         11'd2047, 1'b0});
        tbl.push_back('{OP_RDVEC,  11'd2047, 16'h0,    32'h0,        4'h8, 3'd1, 1, 32'h77770000,  11'd2047, 1'b0});
        tbl.push_back('{OP_STORE,  11'd0,    16'h00AB, 32'h0,        4'h1, 3'd1, 0, 32'h0,         11'd2047, 1'b0});
        tbl.push_back('{OP_POP,    11'd0,    16'h0,    32'h0,        4'h9, 3'd3, 1, 32'h000000AB,  11'd0,    1'b1});
        tbl.push_back('{OP_PUSH,   11'd0,    16'h5555, 32'h0,        4'hB, 3'd1, 0, 32'h0,         11'd2047, 1'b1});
        tbl.push_back('{OP_LOAD,   11'd0,    16'h0,    32'h0,        4'hC, 3'd2, 1, 32'h00005555,  11'd2047, 1'b1});
        tbl.push_back('{OP_POP32,  11'd0,    16'h0,    32'h0,        4'hD, 3'd5, 1, 32'h55550039,  11'd1,    1'b1});
        tbl.push_back('{OP_PUSH32, 11'd0,    16'h0,    32'h13572468, 4'hE, 3'd6, 0, 32'h0,         11'd2047, 1'b1});
        tbl.push_back('{OP_LOAD,   11'd0,    16'h0,    32'h0,        4'hF, 3'd7, 1, 32'h00001357,  11'd2047, 1'b1});
        tbl.push_back('{OP_LOAD,   11'd1,    16'h0,    32'h0,        4'h3, 3'd0, 1, 32'h00002468,  11'd2047, 1'b1});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        foreach (tbl[k]) run_op(tbl[k]);

        // sticky error survives idle cycles
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("err_sticky", {31'b0, o_stackErr}, 32'd1);
        end

        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b1;

        // reset during the second cycle of PUSH32 aborts the high-word write
        run_op('{OP_STORE, 11'd2046, 16'h1111, 32'h0, 4'h2, 3'd2, 0, 32'h0, 11'd2047, 1'b0});
        i_valid  = 1'b1;
        i_op     = OP_PUSH32;
        i_data32 = 32'hAAAABBBB;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'b0, o_busy}, 32'd1);
        rst     = 1'b0;
        i_valid = 1'b0;
        i_op    = OP_NOP;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'b0, o_busy}, 32'd0);
        check("abort_valid", {31'b0, o_valid}, 32'd0);
        check("abort_sp", {21'b0, o_sp}, 32'd2047);
        rst = 1'b1;
        run_op('{OP_LOAD, 11'd2046, 16'h0, 32'h0, 4'h5, 3'd5, 1, 32'h00001111, 11'd2047, 1'b0});
        run_op('{OP_LOAD, 11'd2047, 16'h0, 32'h0, 4'h6, 3'd6, 1, 32'h0000BBBB, 11'd2047, 1'b0});

        @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_mem_unit.md
Name: stack_mem_unit

Overview:
Memory-stage data/stack unit that sits between the ALU→memory pipeline buffer and the memory→writeback buffer. It owns the 16-bit-word data memory and the stack pointer (SP). It executes single-word load/store/push/pop in one cycle. Two-word operations (PC push/pop for call, ret and interrupt, and vector reads for reset and IVT) take two cycles; the unit raises a busy stall during the second cycle.

Parameters:
ADDR_W, 11, word-address width; memory depth is 2^ADDR_W 16-bit words
SP_RESET, 2^ADDR_W-1, SP value after reset (stack grows down)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
i_valid  in  1  operation request this cycle
i_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 PUSH32, 6 POP32, 7 RDVEC
i_addr  in  ADDR_W  word address for LOAD, STORE and RDVEC
i_data16  in  16  store/push data
i_data32  in  32  PUSH32 data (PC)
i_wb  in  4  writeback control, carried alongside the result
i_rdst  in  3  destination register, carried alongside the result
o_busy  out  1  high during the second cycle of a 32-bit op; upstream must hold
o_valid  out  1  result/completion strobe
o_memData  out  32  read data; a 16-bit read is zero-extended
o_wb  out  4  registered i_wb of the completing op
o_rdst  out  3  registered i_rdst of the completing op
o_sp  out  ADDR_W  current SP
o_stackErr  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst==0 at a clk edge): o_valid=0, o_busy=0, o_memData=0, o_wb=0, o_rdst=0, o_sp=SP_RESET, o_stackErr=0, FSM→IDLE. Memory contents are not cleared. A reset mid-operation aborts the op: no second-word write occurs.
- Memory: synchronous write, combinational read, one write port.
- FSM states: IDLE, SECOND.
- IDLE, i_valid=1:
  - LOAD: o_memData={16'b0, mem[i_addr]}.
  - STORE: mem[i_addr]=i_data16.
  - PUSH: mem[SP]=i_data16, SP=SP-1.
  - POP: SP=SP+1, o_memData={16'b0, mem[SP+1]}.
  - Each of the above completes with o_valid=1 on the next edge (latency 1).
  - PUSH32 / POP32 / RDVEC: go to SECOND, o_busy=1, and latch the op, wb, rdst and address.
- Two-word ops:
  - PUSH32 cycle 1: mem[SP]=i_data32[15:0]. Cycle 2: mem[SP-1]=latched [31:16]. Then SP=SP-2.
  - POP32 cycle 1: capture mem[SP+1] as the high word. Cycle 2: capture mem[SP+2] as the low word. Then SP=SP+2.
  - RDVEC: high word = mem[i_addr], low word = mem[i_addr+1]. SP unchanged.
- SECOND: always returns to IDLE. o_valid=1 and o_busy=0 after the edge, so latency is 2. i_valid/i_op are ignored while o_busy=1.
- o_valid is a one-cycle pulse. NOP or i_valid=0 gives o_valid=0, and o_memData/o_wb/o_rdst hold their values.
- SP arithmetic is modulo 2^ADDR_W.
  - PUSH with SP below 1, or PUSH32 with SP below 2 (i.e. a wrap) sets o_stackErr.
  - POP when SP==SP_RESET, or POP32 with SP above SP_RESET-2, sets o_stackErr.
  - The operation still executes with wrapped addresses.
  - o_stackErr clears only on reset.
- Address i_addr+1 wraps modulo depth.

Decomposition:
- Shared package: op-code constants (OP_NOP…OP_RDVEC), FSM state encoding, ADDR_W default, SP_RESET.
- One natural sub-module: dmem_16 (single-port data memory: synchronous write, combinational read, parameter ADDR_W).

Test Plan:
- Reset, then STORE addr 5 = 16'hBEEF, then LOAD addr 5 → next-cycle o_valid=1, o_memData=32'h0000BEEF; o_sp=2047 throughout.
- PUSH 16'h1234 then POP → o_sp 2047→2046→2047; pop result 32'h00001234; o_wb/o_rdst equal the POP's inputs.
- PUSH32 32'hCAFE0057 → o_busy high exactly one cycle, o_sp=2045; then POP32 → o_memData=32'hCAFE0057, o_sp=2047, o_valid on the second edge only.
- STORE mem[0]=16'h0000 and mem[1]=16'h0039, then RDVEC addr 0 → o_memData=32'h00000039 after 2 cycles. A request applied during o_busy is ignored, and memory is unchanged.
- POP at reset SP → o_stackErr=1, o_sp wraps to 0; flag stays high over 10 NOP cycles and clears on rst=0.
- Assert rst=0 during the SECOND cycle of PUSH32 → o_busy=0, o_valid=0, o_sp=2047, and mem[SP-1] not written.
